// File: rtl/water_level_ctrl.sv
// Water tank level controller: synchronised, debounced level sensors drive a fill-pump FSM.
// Optional dry-run protection (pump timeout, fault_code 10) is built only when WLC_DRYRUN_PROT_EN is defined.
module water_level_ctrl #(
    parameter int NUM_LEVELS      = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PUMP_TIMEOUT    = 1000,
    parameter int PUMP_ON_LEVEL   = 1,
    localparam int LW             = $clog2(NUM_LEVELS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_LEVELS-1:0] sensor,
    input  logic                  fault_clr,
    output logic [NUM_LEVELS-1:0] indicator,
    output logic [LW-1:0]         level,
    output logic                  pump_on,
    output logic                  fault,
    output logic [1:0]            fault_code
);

    // state      | meaning
    // ST_IDLE    | pump off, waiting for level to drop to PUMP_ON_LEVEL
    // ST_FILLING | pump on until tank reads full
    // ST_FAULT   | pump off, latched until fault_clr with a consistent indicator
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILLING = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [1:0]            CODE_NONE   = 2'b00;
    localparam logic [1:0]            CODE_INCONS = 2'b01;
    localparam logic [7:0]            DB_LAST     = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [8:0]            SETTLE_INIT = 9'(DEBOUNCE_CYCLES + 2);
    localparam logic [LW-1:0]         ON_LVL      = LW'(PUMP_ON_LEVEL);
    localparam logic [LW-1:0]         FULL_LVL    = LW'(NUM_LEVELS);
    localparam logic [NUM_LEVELS-1:0] ONE_N       = NUM_LEVELS'(1);

    logic [NUM_LEVELS-1:0] sync1_q, sync2_q, ind_q;
    logic [7:0]            db_cnt_q [NUM_LEVELS];
    logic [8:0]            settle_q;
    logic                  settled;
    logic [LW-1:0]         level_c;
    logic                  consistent;
    state_t                state_q, state_d;
    logic [1:0]            code_q, code_d;
    logic                  pump_on_q, pump_on_d;
    logic                  fault_q, fault_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sensor;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ind_q <= '0;
            for (int i = 0; i < NUM_LEVELS; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LEVELS; i++) begin
                if (sync2_q[i] != ind_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        ind_q[i]    <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // Hold off pump start until the indicator has had a full sync+debounce window after reset,
    // so a tank that is actually full is not mistaken for empty by the reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= SETTLE_INIT;
        end else if (settle_q != 9'd0) begin
            settle_q <= settle_q - 9'd1;
        end
    end

    assign settled = (settle_q == 9'd0);

    always_comb begin
        level_c = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            level_c = level_c + {{(LW-1){1'b0}}, ind_q[i]};
        end
    end

    // Thermometer code has no set bit above a clear bit: x & (x+1) is zero exactly then.
    assign consistent = ((ind_q & (ind_q + ONE_N)) == '0);

`ifdef WLC_DRYRUN_PROT_EN
    localparam logic [1:0]  CODE_DRYRUN = 2'b10;
    localparam logic [19:0] TMO_LAST    = 20'(PUMP_TIMEOUT - 1);

    logic [19:0]   tmo_q, tmo_d;
    logic [LW-1:0] level_prev_q;
    logic          level_inc;
    logic          timeout_hit;

    assign level_inc   = (level_c > level_prev_q);
    assign timeout_hit = (state_q == ST_FILLING) && !level_inc && (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d = '0;
        if ((state_q == ST_FILLING) && (state_d == ST_FILLING) && !level_inc) begin
            tmo_d = tmo_q + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q        <= '0;
            level_prev_q <= '0;
        end else begin
            tmo_q        <= tmo_d;
            level_prev_q <= level_c;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            code_q    <= CODE_NONE;
            pump_on_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pump_on_q <= pump_on_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (!consistent) begin
            state_d = ST_FAULT;
            code_d  = CODE_INCONS;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (settled && (level_c <= ON_LVL)) state_d = ST_FILLING;
                end
                ST_FILLING: begin
                    if (level_c == FULL_LVL) begin
                        state_d = ST_IDLE;
                    end
`ifdef WLC_DRYRUN_PROT_EN
                    else if (timeout_hit) begin
                        state_d = ST_FAULT;
                        code_d  = CODE_DRYRUN;
                    end
`endif
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_d = ST_IDLE;
                        code_d  = CODE_NONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    code_d  = CODE_NONE;
                end
            endcase
        end
    end

    always_comb begin
        pump_on_d = (state_d == ST_FILLING);
        fault_d   = (state_d == ST_FAULT);
    end

    assign indicator  = ind_q;
    assign level      = level_c;
    assign pump_on    = pump_on_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_water_level_ctrl.sv
// Directed bench for water_level_ctrl: vector table for steady-state behaviour plus
// hand-written sequences for reset, latency, dry-run timeout and asynchronous reset.
module tb_water_level_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sensor;
    logic       fault_clr;
    logic [3:0] indicator;
    logic [2:0] level;
    logic       pump_on;
    logic       fault;
    logic [1:0] fault_code;

    int checks = 0;
    int errors = 0;

    water_level_ctrl #(
        .NUM_LEVELS     (4),
        .DEBOUNCE_CYCLES(4),
        .PUMP_TIMEOUT   (16),
        .PUMP_ON_LEVEL  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensor    (sensor),
        .fault_clr (fault_clr),
        .indicator (indicator),
        .level     (level),
        .pump_on   (pump_on),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sensor;
        logic       clr;
        int         hold;
        logic [3:0] ind;
        logic [2:0] lvl;
        logic       pump;
        logic       flt;
        logic [1:0] code;
    } vec_t;

    vec_t vecs[17];

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ind, input logic [2:0] lvl,
                           input logic pmp, input logic flt, input logic [1:0] code);
        chk({tag, ".indicator"}, {4'b0, indicator}, {4'b0, ind});
        chk({tag, ".level"}, {5'b0, level}, {5'b0, lvl});
        chk({tag, ".pump_on"}, {7'b0, pump_on}, {7'b0, pmp});
        chk({tag, ".fault"}, {7'b0, fault}, {7'b0, flt});
        chk({tag, ".fault_code"}, {6'b0, fault_code}, {6'b0, code});
    endtask

    // Release reset with the given sensor value and check the pump start boundary.
    task automatic reset_and_start(input string tag, input logic [3:0] s);
        rst_n     = 1'b0;
        sensor    = s;
        fault_clr = 1'b0;
        tick(2);
        chk_all({tag, ".in_reset"}, 4'b0000, 3'd0, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;
        tick(6);
        chk({tag, ".pump_before_settle"}, {7'b0, pump_on}, 8'd0);
        tick(1);
        chk({tag, ".pump_after_settle"}, {7'b0, pump_on}, 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            sensor  clr  hold ind      lvl   pump  flt   code
        vecs[0]  = '{4'b0011, 1'b0, 10, 4'b0011, 3'd2, 1'b1, 1'b0, 2'b00};
        vecs[1]  = '{4'b0111, 1'b0, 10, 4'b0111, 3'd3, 1'b1, 1'b0, 2'b00};
        vecs[2]  = '{4'b1111, 1'b0,  6, 4'b1111, 3'd4, 1'b1, 1'b0, 2'b00};
        vecs[3]  = '{4'b1111, 1'b0,  1, 4'b1111, 3'd4, 1'b0, 1'b0, 2'b00};
        vecs[4]  = '{4'b0011, 1'b0, 10, 4'b0011, 3'd2, 1'b0, 1'b0, 2'b00};
        vecs[5]  = '{4'b0001, 1'b0, 10, 4'b0001, 3'd1, 1'b1, 1'b0, 2'b00};
        vecs[6]  = '{4'b0101, 1'b0,  6, 4'b0101, 3'd2, 1'b1, 1'b0, 2'b00};
        vecs[7]  = '{4'b0101, 1'b0,  1, 4'b0101, 3'd2, 1'b0, 1'b1, 2'b01};
        vecs[8]  = '{4'b0101, 1'b1,  3, 4'b0101, 3'd2, 1'b0, 1'b1, 2'b01};
        vecs[9]  = '{4'b0111, 1'b0, 10, 4'b0111, 3'd3, 1'b0, 1'b1, 2'b01};
        vecs[10] = '{4'b0111, 1'b1,  1, 4'b0111, 3'd3, 1'b0, 1'b0, 2'b00};
        vecs[11] = '{4'b0111, 1'b1,  3, 4'b0111, 3'd3, 1'b0, 1'b0, 2'b00};
        vecs[12] = '{4'b0011, 1'b0, 10, 4'b0011, 3'd2, 1'b0, 1'b0, 2'b00};
        vecs[13] = '{4'b0111, 1'b0,  1, 4'b0011, 3'd2, 1'b0, 1'b0, 2'b00};
        vecs[14] = '{4'b0011, 1'b0, 10, 4'b0011, 3'd2, 1'b0, 1'b0, 2'b00};
        vecs[15] = '{4'b0111, 1'b0,  3, 4'b0011, 3'd2, 1'b0, 1'b0, 2'b00};
        vecs[16] = '{4'b0011, 1'b0, 10, 4'b0011, 3'd2, 1'b0, 1'b0, 2'b00};

        @(posedge clk);
        #1;
        reset_and_start("empty", 4'b0000);
        chk_all("empty_filling", 4'b0000, 3'd0, 1'b1, 1'b0, 2'b00);

        // Clean step: indicator must move exactly 6 cycles after the raw edge.
        sensor = 4'b0001;
        tick(5);
        chk("step.ind_at5", {4'b0, indicator}, 8'h00);
        tick(1);
        chk("step.ind_at6", {4'b0, indicator}, 8'h01);
        chk("step.level", {5'b0, level}, 8'd1);

        for (int i = 0; i < 17; i++) begin
            sensor    = vecs[i].sensor;
            fault_clr = vecs[i].clr;
            tick(vecs[i].hold);
            chk_all($sformatf("row%0d", i), vecs[i].ind, vecs[i].lvl,
                    vecs[i].pump, vecs[i].flt, vecs[i].code);
        end
        fault_clr = 1'b0;

        // Dry run: sensor frozen at level 1, FILLING lasts 16 cycles before timeout.
        reset_and_start("dry", 4'b0001);
        tick(15);
        chk_all("dry_edge15", 4'b0001, 3'd1, 1'b1, 1'b0, 2'b00);
        tick(1);
`ifdef WLC_DRYRUN_PROT_EN
        chk_all("dry_timeout", 4'b0001, 3'd1, 1'b0, 1'b1, 2'b10);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        chk_all("dry_clr", 4'b0001, 3'd1, 1'b0, 1'b0, 2'b00);
        tick(1);
        chk("dry_refill.pump", {7'b0, pump_on}, 8'd1);
`else
        chk_all("dry_no_timeout", 4'b0001, 3'd1, 1'b1, 1'b0, 2'b00);
        tick(20);
        chk_all("dry_still_filling", 4'b0001, 3'd1, 1'b1, 1'b0, 2'b00);
`endif

        // Asynchronous reset mid-FILLING, mid-cycle.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'b0000, 3'd0, 1'b0, 1'b0, 2'b00);
        tick(1);
        reset_and_start("after_rst", 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/water_level_ctrl.md
WATER_LEVEL_CTRL -- requirements
Module: water_level_ctrl

Interface
REQ-001 SHALL provide parameter NUM_LEVELS, default 4, number of level sensors (2..16), bit 0 = lowest sensor.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept a sensor change (1..255).
REQ-003 SHALL provide parameter PUMP_TIMEOUT, default 1000, maximum cycles in FILLING without a level increase (1..2^20-1).
REQ-004 SHALL provide parameter PUMP_ON_LEVEL, default 1, pump starts when level <= this value (0..NUM_LEVELS-1).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 sensor  input  NUM_LEVELS  raw asynchronous wet flags, 1 = water at that height.
REQ-008 fault_clr  input  1  synchronous request to leave FAULT.
REQ-009 indicator  output  NUM_LEVELS  debounced sensor vector.
REQ-010 level  output  LW = clog2(NUM_LEVELS+1)  count of set bits in indicator.
REQ-011 pump_on  output  1  pump drive, registered.
REQ-012 fault  output  1  high while in FAULT, registered.
REQ-013 fault_code  output  2  00 none, 01 inconsistent pattern, 10 dry-run timeout.

Function
REQ-014 Each sensor bit SHALL pass a 2-flop synchroniser, then a per-bit debounce counter; indicator bit updates when synchronised value differs from indicator for DEBOUNCE_CYCLES consecutive cycles; any reversion resets that bit's counter.
REQ-015 Latency raw edge -> indicator SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean step.
REQ-016 level SHALL be combinational popcount of indicator, width LW, no overflow possible.
REQ-017 indicator SHALL be "consistent" when it is thermometer code (no set bit above a clear bit); all-zero and all-one are consistent.
REQ-018 FSM states IDLE, FILLING, FAULT; encoding implementer's choice; pump_on = 1 only in FILLING.
REQ-019 IDLE -> FILLING when consistent and level <= PUMP_ON_LEVEL.
REQ-020 FILLING -> IDLE when consistent and level == NUM_LEVELS (hysteresis: pump does not stop between PUMP_ON_LEVEL and full).
REQ-021 Any state -> FAULT with fault_code 01 when indicator inconsistent; this check has priority over all other transitions in the same cycle.
REQ-022 In FILLING, a timeout counter SHALL reload to 0 on entry and whenever level increases versus the previous cycle; reaching PUMP_TIMEOUT SHALL go to FAULT with fault_code 10.
REQ-023 Level decrease in FILLING SHALL NOT reload the timeout counter.
REQ-024 FAULT -> IDLE only when fault_clr = 1 and indicator consistent; fault_code returns to 00 in the same transition; fault_clr ignored outside FAULT.
REQ-025 fault_clr while still inconsistent SHALL leave FAULT and fault_code unchanged.
REQ-026 Outputs pump_on, fault, fault_code SHALL reflect the state registered one cycle after the causing indicator/level change.

Reset
REQ-027 rst_n low SHALL asynchronously force: synchronisers, indicator, debounce counters, timeout counter = 0; state IDLE; pump_on 0; fault 0; fault_code 00.
REQ-028 Reset mid-FILLING or mid-FAULT SHALL drop pump_on immediately without waiting for clk; after release, a level-0 indicator enters FILLING only after normal debounce.

Configuration
REQ-029 Macro WLC_DRYRUN_PROT_EN: when defined, REQ-022/023 timeout logic and fault_code 10 are present; when undefined, no timeout counter exists, FILLING leaves only via REQ-020/021, and fault_code never takes 10.

Verification (NUM_LEVELS=4, DEBOUNCE_CYCLES=4, PUMP_TIMEOUT=16, PUMP_ON_LEVEL=1, macro defined)
REQ-030 Reset, sensor=0000 held -> indicator 0000, level 0, pump_on 1 exactly one cycle after debounce settles; sensor step to 0001 -> indicator 0001 exactly 6 cycles later.
REQ-031 Fill sequence 0001,0011,0111,1111 each held 10 cycles -> pump_on stays 1 through 0111, falls 1 cycle after indicator=1111; drain 1111->0011 keeps pump_on 0, 0001 restarts pump.
REQ-032 1-cycle and 3-cycle glitches on sensor[2] -> indicator unchanged, no state change.
REQ-033 sensor=0101 held -> fault 1, fault_code 01, pump_on 0; fault_clr while 0101 -> still FAULT; sensor=0111 then fault_clr -> IDLE, fault_code 00.
REQ-034 Filling with sensor frozen at 0001 -> fault_code 10 after 16 cycles in FILLING, pump_on 0; with macro undefined same stimulus -> pump_on remains 1, fault 0.
REQ-035 rst_n asserted mid-FILLING, asynchronous to clk -> pump_on 0 before next clk edge; all outputs at reset values.
